// File: rtl/generic_flash_access_memory_arbiter.sv
// Round-robin arbiter sharing one single-port main RAM between two
// Avalon-MM requesters, with address range checking and tagged read return.
module generic_flash_access_memory_arbiter #(
  parameter int DEPTH = 10240,
  parameter int AW    = 14,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     m0_address,
  input  logic [DW/8-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DW-1:0]     m0_writedata,
  output logic              m0_waitrequest,
  output logic [DW-1:0]     m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [AW-1:0]     m1_address,
  input  logic [DW/8-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DW-1:0]     m1_writedata,
  output logic              m1_waitrequest,
  output logic [DW-1:0]     m1_readdata,
  output logic              m1_readdatavalid,
  output logic [AW-1:0]     ram_address,
  output logic [DW/8-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DW-1:0]     ram_writedata,
  input  logic [DW-1:0]     ram_readdata,
  output logic [1:0]        oor_flag,
  input  logic              oor_clear
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic            w_req0;
  logic            w_req1;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_any;
  logic            w_valid;
  logic            w_wr;
  logic            w_oor;
  logic            w_rd;
  logic [1:0]      w_oor_set;
  logic [AW-1:0]   w_addr;
  logic [DW/8-1:0] w_be;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   w_rdata;

  logic            r_last_grant;
  logic            r_rv;
  logic            r_rid;
  logic            r_roor;
  logic [1:0]      r_oor_flag;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // r_last_grant = 1 means port 1 was served last, so port 0 has priority
  assign w_gnt0 = w_req0 & (~w_req1 | r_last_grant);
  assign w_gnt1 = w_req1 & (~w_req0 | ~r_last_grant);
  assign w_any  = w_gnt0 | w_gnt1;

  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  assign w_addr  = w_gnt1 ? m1_address    : m0_address;
  assign w_be    = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign w_wdata = w_gnt1 ? m1_writedata  : m0_writedata;
  assign w_wr    = w_gnt1 ? m1_write      : m0_write;

  assign w_oor   = {1'b0, w_addr} >= LP_DEPTH;
  assign w_valid = w_any & ~reset;
  // a write with read also high is a write only; the read is dropped
  assign w_rd    = w_valid & ~w_wr;

  assign w_oor_set = {w_gnt1, w_gnt0} & {2{w_valid & w_oor}};

  assign ram_address    = w_addr;
  assign ram_byteenable = w_be;
  assign ram_writedata  = w_wdata;
  assign ram_chipselect = w_valid & ~w_oor;
  assign ram_write      = w_valid & w_wr & ~w_oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rv         <= 1'b0;
      r_rid        <= 1'b0;
      r_roor       <= 1'b0;
      r_oor_flag   <= 2'b00;
    end else begin
      if (w_any) begin
        r_last_grant <= w_gnt1;
      end
      r_rv       <= w_rd;
      r_rid      <= w_gnt1;
      r_roor     <= w_oor;
      r_oor_flag <= (r_oor_flag & {2{~oor_clear}}) | w_oor_set;
    end
  end

  assign w_rdata = r_roor ? '0 : ram_readdata;

  assign m0_readdata      = w_rdata;
  assign m1_readdata      = w_rdata;
  assign m0_readdatavalid = r_rv & ~r_rid;
  assign m1_readdatavalid = r_rv & r_rid;
  assign oor_flag         = r_oor_flag;

endmodule

// File: tb/tb_generic_flash_access_memory_arbiter.sv
// Directed plus randomized bench for the two-port RAM arbiter with a
// behavioural RAM and a transaction-level reference model.
module tb_generic_flash_access_memory_arbiter;
  localparam int DEPTH = 10240;
  localparam int AW    = 14;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] m0_address = '0;
  logic [3:0]    m0_byteenable = '0;
  logic          m0_read = 1'b0;
  logic          m0_write = 1'b0;
  logic [31:0]   m0_writedata = '0;
  logic          m0_waitrequest;
  logic [31:0]   m0_readdata;
  logic          m0_readdatavalid;
  logic [AW-1:0] m1_address = '0;
  logic [3:0]    m1_byteenable = '0;
  logic          m1_read = 1'b0;
  logic          m1_write = 1'b0;
  logic [31:0]   m1_writedata = '0;
  logic          m1_waitrequest;
  logic [31:0]   m1_readdata;
  logic          m1_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [3:0]    ram_byteenable;
  logic          ram_chipselect;
  logic          ram_write;
  logic [31:0]   ram_writedata;
  logic [31:0]   ram_readdata = '0;
  logic [1:0]    oor_flag;
  logic          oor_clear = 1'b0;

  logic [31:0] ram_mem [DEPTH];
  logic [31:0] gold    [DEPTH];

  int tests = 0;
  int fails = 0;

  // reference model state
  bit          m_last;
  bit          m_pv;
  bit          m_pid;
  logic [31:0] m_pd;
  logic [1:0]  m_flag;
  bit          m_w0;
  bit          m_w1;

  generic_flash_access_memory_arbiter #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .oor_flag(oor_flag), .oor_clear(oor_clear)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM, q registered one cycle after address
  always @(posedge clk) begin
    if (ram_chipselect && int'(ram_address) < DEPTH) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b])
            ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: predict, check mid-cycle, advance model, step past edge
  task automatic tick();
    bit q0, q1, g0, g1, wr, oor;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   d;
    if (reset) begin
      m_last = 1'b1;
      m_pv   = 1'b0;
      m_flag = 2'b00;
    end
    q0 = m0_read || m0_write;
    q1 = m1_read || m1_write;
    if (q0 && q1) begin
      g0 = m_last;
      g1 = !m_last;
    end else begin
      g0 = q0;
      g1 = q1;
    end
    a   = g1 ? m1_address : m0_address;
    wr  = g1 ? m1_write : m0_write;
    be  = g1 ? m1_byteenable : m0_byteenable;
    d   = g1 ? m1_writedata : m0_writedata;
    oor = int'(a) >= DEPTH;
    m_w0 = q0 && !g0;
    m_w1 = q1 && !g1;
    @(negedge clk);
    chk("m0_waitrequest", m0_waitrequest, m_w0);
    chk("m1_waitrequest", m1_waitrequest, m_w1);
    chk("m0_readdatavalid", m0_readdatavalid, m_pv && !m_pid);
    chk("m1_readdatavalid", m1_readdatavalid, m_pv && m_pid);
    if (m_pv) begin
      chk("m0_readdata", m0_readdata, m_pd);
      chk("m1_readdata", m1_readdata, m_pd);
    end
    chk("oor_flag", oor_flag, m_flag);
    if (!reset) begin
      chk("ram_chipselect", ram_chipselect, (g0 || g1) && !oor);
      chk("ram_write", ram_write, (g0 || g1) && wr && !oor);
      if ((g0 || g1) && !oor) begin
        chk("ram_address", ram_address, a);
      end
      m_pv  = (g0 || g1) && !wr;
      m_pid = g1;
      m_pd  = '0;
      if (!oor) m_pd = gold[a];
      if ((g0 || g1) && wr && !oor) gold[a] = merge(gold[a], d, be);
      m_flag = (oor_clear ? 2'b00 : m_flag) | {g1 && oor, g0 && oor};
      if (g0 || g1) m_last = g1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(output logic r, output logic w,
                           output logic [AW-1:0] a, output logic [3:0] be,
                           output logic [31:0] d);
    int k;
    k = $urandom_range(0, 9);
    r = (k >= 3 && k <= 5) || k == 9;
    w = k >= 6;
    if ($urandom_range(0, 11) == 0)
      a = AW'($urandom_range(DEPTH, (1 << AW) - 1));
    else
      a = AW'($urandom_range(0, 31));
    be = 4'($urandom_range(0, 15));
    d  = $urandom;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  int cnt0, cnt1;

  initial begin
    for (int i = 0; i < DEPTH; i++) gold[i] = (i * 32'h01010101) ^ 32'hA5A50000;
    gold[5]  = 32'h12345678;
    gold[16] = 32'h11223344;
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = gold[i];
    m_last = 1; m_pv = 0; m_pid = 0; m_pd = '0; m_flag = '0;
    m_w0 = 0; m_w1 = 0;

    #1 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // uncontended read
    m0_read = 1; m0_address = 14'h0005;
    tick();
    idle();
    chk("uncont_valid", m0_readdatavalid, 1'b1);
    chk("uncont_data", m0_readdata, 32'h12345678);
    chk("uncont_m1_valid", m1_readdatavalid, 1'b0);
    tick();

    // contention from reset: strict alternation starting with m0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_read = 1; m0_address = 14'h0005;
    m1_read = 1; m1_address = 14'h0006;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt0 += int'(m0_readdatavalid);
      cnt1 += int'(m1_readdatavalid);
    end
    idle();
    chk("contention_cnt0", cnt0, 4);
    chk("contention_cnt1", cnt1, 4);
    tick();

    // byte-lane write then read-back
    m1_write = 1; m1_address = 14'h0010;
    m1_byteenable = 4'b0101; m1_writedata = 32'hAABBCCDD;
    tick();
    m1_write = 0; m1_read = 1;
    tick();
    idle();
    chk("byte_valid", m1_readdatavalid, 1'b1);
    chk("byte_merge", m1_readdata, 32'h11BB33DD);
    tick();

    // out-of-range write, read, clear, clear-vs-set
    m0_write = 1; m0_address = 14'd10240; m0_writedata = 32'hDEADBEEF;
    m0_byteenable = 4'hF;
    tick();
    m0_write = 0; m0_read = 1; m0_address = 14'h3FFF;
    tick();
    idle();
    chk("oor_flag_set", oor_flag, 2'b01);
    chk("oor_read_valid", m0_readdatavalid, 1'b1);
    chk("oor_read_zero", m0_readdata, 32'h0);
    oor_clear = 1;
    tick();
    oor_clear = 0;
    chk("oor_cleared", oor_flag, 2'b00);
    oor_clear = 1; m1_read = 1; m1_address = 14'h3FFF;
    tick();
    idle();
    oor_clear = 0;
    chk("oor_set_wins", oor_flag, 2'b10);
    oor_clear = 1;
    tick();
    oor_clear = 0;

    // read and write together: only the write happens
    m0_read = 1; m0_write = 1; m0_address = 14'h0020;
    m0_writedata = 32'hCAFEF00D; m0_byteenable = 4'hF;
    tick();
    idle();
    chk("rw_no_valid", m0_readdatavalid, 1'b0);
    tick();
    m0_read = 1; m0_address = 14'h0020;
    tick();
    idle();
    chk("rw_written", m0_readdata, 32'hCAFEF00D);
    tick();

    // reset during a pending read drops it
    m0_read = 1; m0_address = 14'h0005;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_drop_valid", m0_readdatavalid, 1'b0);
    tick();
    m0_read = 1; m1_read = 1;
    m0_address = 14'h0007; m1_address = 14'h0008;
    tick();
    chk("post_reset_m0_first", m0_readdatavalid, 1'b1);
    tick();
    idle();
    tick();

    // randomized traffic honouring the hold-while-waiting rule
    for (int i = 0; i < 400; i++) begin
      if (!m_w0)
        rand_port(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
      if (!m_w1)
        rand_port(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
      oor_clear = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    oor_clear = 0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/generic_flash_access_memory_arbiter.md
# generic_flash_access_memory_arbiter

Two-port round-robin arbiter that shares the single-port 10240×32 on-chip main memory between two Avalon-MM requesters (e.g. CPU data master and flash-copy DMA). It sits between the requesters and the RAM's port, issues at most one RAM access per clock, and returns read data tagged to the issuing port. It also range-checks addresses against the populated depth, drops out-of-range writes and flags them.

## Interface
- DEPTH, 10240: populated words; addresses >= DEPTH are out of range.
- AW, 14: word address width.
- DW, 32: data width; byteenable width is DW/8.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- m0_address / m1_address  in  AW  word address of requester 0 / 1.
- m0_byteenable / m1_byteenable  in  DW/8  byte lanes for writes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DW  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DW  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid this cycle.
- ram_address  out  AW  to RAM address.
- ram_byteenable  out  DW/8  to RAM byteenable.
- ram_chipselect  out  1  RAM access this cycle.
- ram_write  out  1  RAM write strobe.
- ram_writedata  out  DW  to RAM writedata.
- ram_readdata  in  DW  RAM q; valid the cycle after address is presented.
- oor_flag  out  2  sticky out-of-range flag per port (bit0 = m0).
- oor_clear  in  1  synchronous clear of oor_flag.

## Operation
- Request: port n requests when mn_read | mn_write. Read and write both high: write wins, read ignored (not queued).
- Arbitration: combinational, one grant per cycle. One requester: it wins. Both: port != last_grant wins. last_grant register updates to granted port on every grant; reset value 1, so m0 wins first contention.
- waitrequest: mn_waitrequest = request_n & ~grant_n. Zero when not requesting. Requester holds signals stable until waitrequest low (Avalon rule).
- RAM drive: granted port's address/byteenable/writedata muxed to ram_*; ram_chipselect = any grant; ram_write = granted write. No grant: ram_chipselect = 0, ram_write = 0, other ram_* hold port-0 mux value (don't care).
- Range check: address >= DEPTH on a granted access -> ram_chipselect and ram_write forced 0; oor_flag[n] set on next edge. Read still completes: readdatavalid pulses with readdata = 0. Grant and last_grant still update.
- Read return pipeline: registers rv (valid), rid (port), roor (out-of-range). Set from granted read; cleared otherwise. In cycle after grant: mn_readdatavalid = rv & (rid == n); mn_readdata = roor ? 0 : ram_readdata (both ports see the same readdata bus value; only valid is steered).
- Writes: posted, no response. Write at cycle N followed by read of same address at N+1 returns the new data.
- oor_clear: clears both flags. Coincides with a new out-of-range access: set wins.
- Reset (async assert, sync-released): rv=0, rid=0, roor=0, last_grant=1, oor_flag=0. During reset, waitrequest follows the combinational rule, but no RAM access is counted valid. Reset during a pending read drops it: no readdatavalid after release.

## Timing
- Accept latency: 0 cycles uncontended; at most 1 extra cycle under contention per transaction (strict alternation).
- Read latency: grant in cycle N -> readdatavalid in cycle N+1, exactly one cycle.
- Throughput: one access per cycle total; back-to-back reads from alternating ports produce alternating valids every cycle.
- oor_flag visible the cycle after the offending grant.
- No combinational path from ram_readdata to any ram_* output.

## Test plan
- Uncontended read: m0_read, addr 0x0005 (RAM preloaded 0x12345678) -> m0_waitrequest=0 that cycle; next cycle m0_readdatavalid=1, m0_readdata=0x12345678; m1_readdatavalid=0.
- Contention: m0 and m1 both read continuously from reset -> grants m0,m1,m0,m1; each port's waitrequest high on alternate cycles; 4 valids per port over 8 cycles.
- Byte write then read: m1 write 0xAABBCCDD, be=4'b0101, addr 0x0010 (old 0x11223344), then m1 read next cycle -> 0x11BB33DD one cycle later.
- Out of range: m0 write addr 10240 -> ram_chipselect=0, oor_flag=2'b01 next cycle; m0 read addr 0x3FFF -> readdatavalid with 0x00000000; oor_clear -> flag 0.
- Read+write same cycle on m0 -> only the write reaches RAM, no readdatavalid.
- Reset mid-read: assert reset the cycle after a grant -> no readdatavalid; after release, first contention grants m0.
